// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus.
// Holds the program/data RAM and decodes the I/O window at 0x30000
// (UART TX FIFO push, UART RX pop, cycle counter bytes, program-stop flag).
// Read data is registered: valid the cycle after an accepted read.
// Optional build macro: MEM_IO_CYCLE_SNAPSHOT_EN -- a read of 0x30004 latches
// the full cycle counter so that 0x30005..0x30007 return a coherent word.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int FULL_MARGIN    = 2,
    parameter     RAM_INIT_FILE  = ""
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_wdata,
    input  logic        mem_wr,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop
);

    localparam int unsigned DEPTH         = 1 << TX_DEPTH_LOG2;
    localparam int unsigned FULL_LEVEL    = DEPTH - FULL_MARGIN;
    localparam logic [TX_DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};
    localparam logic [TX_DEPTH_LOG2:0]   CNT_ONE   = {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [TX_DEPTH_LOG2-1:0] PTR_ONE   = {{(TX_DEPTH_LOG2-1){1'b0}}, 1'b1};

    // ---------------- address decode ----------------
    logic                      io_sel;
    logic [15:0]               io_off;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;
    logic                      rd_req;
    logic                      wr_req;
    logic                      unused_addr_hi;

    assign io_sel         = (mem_a[17:16] == 2'b11);
    assign io_off         = mem_a[15:0];
    assign ram_idx        = mem_a[RAM_ADDR_WIDTH-1:0];
    assign rd_req         = rdy_in && !mem_wr;
    assign wr_req         = rdy_in && mem_wr;
    assign unused_addr_hi = ^mem_a[31:18];

    // ---------------- RAM ----------------
    logic [7:0] ram [0:(1 << RAM_ADDR_WIDTH)-1];
    logic [7:0] ram_rd;

    // RAM port: write-through is not needed, a read the next cycle sees the new byte
    always_ff @(posedge clk_in) begin
        if (wr_req && !io_sel) begin
            ram[ram_idx] <= mem_wdata;
        end
        if (rd_req && !io_sel) begin
            ram_rd <= ram[ram_idx];
        end
    end

    // ---------------- cycle counter ----------------
    logic [31:0] cycle_cnt;

    // Free-running counter, independent of rdy_in, wraps naturally
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    logic [31:0] cnt_view;

`ifdef MEM_IO_CYCLE_SNAPSHOT_EN
    logic [31:0] snapshot;

    // Byte-0 read captures the whole counter for the following upper-byte reads
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            snapshot <= '0;
        end else if (rd_req && io_sel && io_off == 16'h0004) begin
            snapshot <= cycle_cnt;
        end
    end

    assign cnt_view = (io_off[1:0] == 2'd0) ? cycle_cnt : snapshot;
`else
    assign cnt_view = cycle_cnt;
`endif

    // ---------------- I/O read data ----------------
    logic [7:0] io_rd_value;

    // I/O read mux: RX byte, counter byte, or zero for unmapped offsets
    always_comb begin
        io_rd_value = '0;
        if (io_off == 16'h0000) begin
            io_rd_value = rx_valid ? rx_data : 8'h00;
        end else if (io_off[15:2] == 14'h0001) begin
            case (io_off[1:0])
                2'd0:    io_rd_value = cnt_view[7:0];
                2'd1:    io_rd_value = cnt_view[15:8];
                2'd2:    io_rd_value = cnt_view[23:16];
                default: io_rd_value = cnt_view[31:24];
            endcase
        end
    end

    logic       rd_from_ram;
    logic [7:0] io_rdata;

    // Read-source select and I/O data; both hold unless a read is accepted
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_from_ram <= 1'b0;
            io_rdata    <= '0;
        end else if (rd_req) begin
            rd_from_ram <= !io_sel;
            io_rdata    <= io_rd_value;
        end
    end

    // RAM data stays in its own unreset register; reset forces the I/O path (zero)
    assign mem_rdata = rd_from_ram ? ram_rd : io_rdata;

    // RX pop pulses combinationally during the accepted read of 0x30000
    always_comb begin
        rx_pop = rst_in && rd_req && io_sel && (io_off == 16'h0000) && rx_valid;
    end

    // ---------------- program stop ----------------
    // Sticky until reset
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            program_stop <= 1'b0;
        end else if (wr_req && io_sel && io_off == 16'h0004) begin
            program_stop <= 1'b1;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]               tx_mem [0:DEPTH-1];
    logic [TX_DEPTH_LOG2-1:0] wr_ptr;
    logic [TX_DEPTH_LOG2-1:0] rd_ptr;
    logic [TX_DEPTH_LOG2:0]   tx_count;
    logic [TX_DEPTH_LOG2:0]   count_next;
    logic                     push_req;
    logic [7:0]               push_data;
    logic                     push_ok;
    logic                     tx_pop;

    assign tx_valid = (tx_count != '0);
    assign tx_data  = tx_mem[rd_ptr];

    // Push/pop decisions; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        push_req  = 1'b0;
        push_data = mem_wdata;
        if (wr_req && io_sel) begin
            if (io_off == 16'h0000 && mem_wdata != 8'h00) begin
                push_req = 1'b1;
            end else if (io_off == 16'h0004) begin
                push_req  = 1'b1;
                push_data = 8'h00;
            end
        end
        tx_pop     = tx_valid && tx_ready;
        push_ok    = push_req && ((tx_count != DEPTH_CNT) || tx_pop);
        count_next = tx_count;
        if (push_ok && !tx_pop) begin
            count_next = tx_count + CNT_ONE;
        end else if (!push_ok && tx_pop) begin
            count_next = tx_count - CNT_ONE;
        end
    end

    // FIFO pointers, occupancy and near-full flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            tx_count       <= '0;
            io_buffer_full <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            tx_count       <= count_next;
            io_buffer_full <= (32'(count_next) >= FULL_LEVEL);
        end
    end

    // FIFO storage, no reset needed (occupancy gates visibility)
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Testbench for mem_io_responder: directed vectors, a queue/array model of the
// bus behaviour checked every cycle, and literal expectations at key points.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_stop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(
        .RAM_ADDR_WIDTH(17),
        .TX_DEPTH_LOG2 (4),
        .FULL_MARGIN   (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .mem_a         (mem_a),
        .mem_wdata     (mem_wdata),
        .mem_wr        (mem_wr),
        .mem_rdata     (mem_rdata),
        .io_buffer_full(io_buffer_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop),
        .program_stop  (program_stop)
    );

    // ---------------- behavioural model ----------------
    logic [7:0]  m_ram [logic [16:0]];
    logic [7:0]  m_q [$];
    logic [7:0]  m_rdata = 8'h00;
    bit          m_known = 1'b1;
    bit          m_full  = 1'b0;
    bit          m_stop  = 1'b0;
    logic [31:0] m_cnt   = 32'h0;
    logic [31:0] m_snap  = 32'h0;
    int          preset_seq = 0;
    int          seen_seq   = 0;
    logic [31:0] preset_val = 32'h0;

    always @(posedge clk_in or negedge rst_in) begin : model
        logic [15:0] off;
        logic [31:0] view;
        bit          io;
        bit          pop;
        bit          push;
        logic [7:0]  pd;
        if (!rst_in) begin
            m_q.delete();
            m_rdata = 8'h00;
            m_known = 1'b1;
            m_full  = 1'b0;
            m_stop  = 1'b0;
            m_cnt   = 32'h0;
            m_snap  = 32'h0;
        end else begin
            if (preset_seq != seen_seq) begin
                m_cnt    = preset_val;
                seen_seq = preset_seq;
            end
            io   = (mem_a[17:16] == 2'b11);
            off  = mem_a[15:0];
            pop  = (m_q.size() > 0) && tx_ready;
            push = 1'b0;
            pd   = mem_wdata;
            if (rdy_in && mem_wr) begin
                if (!io) m_ram[mem_a[16:0]] = mem_wdata;
                else if (off == 16'h0 && mem_wdata != 8'h00) push = 1'b1;
                else if (off == 16'h4) begin
                    push   = 1'b1;
                    pd     = 8'h00;
                    m_stop = 1'b1;
                end
            end else if (rdy_in) begin
                if (!io) begin
                    m_known = m_ram.exists(mem_a[16:0]);
                    if (m_known) m_rdata = m_ram[mem_a[16:0]];
                end else begin
                    m_known = 1'b1;
                    if (off == 16'h0) m_rdata = rx_valid ? rx_data : 8'h00;
                    else if (off >= 16'h4 && off <= 16'h7) begin
`ifdef MEM_IO_CYCLE_SNAPSHOT_EN
                        view = (off == 16'h4) ? m_cnt : m_snap;
                        if (off == 16'h4) m_snap = m_cnt;
`else
                        view = m_cnt;
`endif
                        m_rdata = 8'(view >> (8 * off[1:0]));
                    end else m_rdata = 8'h00;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (push && m_q.size() < 16) m_q.push_back(pd);
            m_full = (m_q.size() >= 14);
            m_cnt  = m_cnt + 32'd1;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        bit exp_pop;
        exp_pop = rst_in && rdy_in && !mem_wr && (mem_a[17:0] == 18'h30000) && rx_valid;
        if (m_known) chk("model mem_rdata", {24'h0, mem_rdata}, {24'h0, m_rdata});
        chk("model tx_valid", {31'h0, tx_valid}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) chk("model tx_data", {24'h0, tx_data}, {24'h0, m_q[0]});
        chk("model io_buffer_full", {31'h0, io_buffer_full}, {31'h0, m_full});
        chk("model program_stop", {31'h0, program_stop}, {31'h0, m_stop});
        chk("model rx_pop", {31'h0, rx_pop}, {31'h0, exp_pop});
    endtask

    task automatic cyc();
        @(negedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input logic [7:0] d);
        rdy_in    = r;
        mem_a     = a;
        mem_wr    = w;
        mem_wdata = d;
        cyc();
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 8'h00);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] e;
        rdy_in = 0; mem_a = 0; mem_wr = 0; mem_wdata = 0;
        tx_ready = 0; rx_data = 0; rx_valid = 0;
        repeat (3) cyc();
        chk("reset mem_rdata", {24'h0, mem_rdata}, 32'h0);
        chk("reset tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset program_stop", {31'h0, program_stop}, 32'h0);
        chk("reset io_buffer_full", {31'h0, io_buffer_full}, 32'h0);
        rst_in = 1'b1;

        // RAM round trips
        drive(1, 32'h0001_0, 1, 8'hA5);
        drive(1, 32'h0001_0, 0, 8'h00);
        chk("ram read 0x10", {24'h0, mem_rdata}, 32'hA5);
        drive(1, 32'h1FFFF, 1, 8'h3C);
        drive(1, 32'h1FFFF, 0, 8'h00);
        chk("ram read 0x1FFFF", {24'h0, mem_rdata}, 32'h3C);

        // rdy_in low: nothing happens, read data holds
        drive(0, 32'h10, 1, 8'h55);
        drive(0, 32'h30000, 1, 8'h99);
        drive(0, 32'h10, 0, 8'h00);
        chk("rdy low rdata held", {24'h0, mem_rdata}, 32'h3C);
        chk("rdy low no push", {31'h0, tx_valid}, 32'h0);
        drive(1, 32'h10, 0, 8'h00);
        chk("rdy low ram kept", {24'h0, mem_rdata}, 32'hA5);

        // zero byte is not pushed
        drive(1, 32'h30000, 1, 8'h00);
        chk("zero push ignored", {31'h0, tx_valid}, 32'h0);

        // fill FIFO with tx_ready low
        tx_ready = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1, 32'h30000, 1, 8'(8'h41 + i));
            if (i == 12) chk("not full after 13", {31'h0, io_buffer_full}, 32'h0);
            if (i == 13) chk("full after 14", {31'h0, io_buffer_full}, 32'h1);
        end
        drive(1, 32'h30000, 1, 8'hEE);
        tx_ready = 1;
        drive(1, 32'h30000, 1, 8'h77);
        tx_ready = 0;
        idle();
        chk("full kept on push+pop", {31'h0, io_buffer_full}, 32'h1);
        tx_ready = 1;
        for (int k = 0; k < 16; k++) begin
            e = (k < 15) ? 8'(8'h42 + k) : 8'h77;
            chk("drain order", {24'h0, tx_data}, {24'h0, e});
            idle();
        end
        chk("drained empty", {31'h0, tx_valid}, 32'h0);
        chk("drained not full", {31'h0, io_buffer_full}, 32'h0);
        tx_ready = 0;

        // program stop
        drive(1, 32'h30004, 1, 8'h12);
        chk("stop pushes entry", {31'h0, tx_valid}, 32'h1);
        chk("stop pushes zero", {24'h0, tx_data}, 32'h0);
        chk("stop set", {31'h0, program_stop}, 32'h1);
        tx_ready = 1;
        idle();
        tx_ready = 0;
        repeat (2) idle();
        chk("stop sticky", {31'h0, program_stop}, 32'h1);

        // RX pop
        rx_valid = 1; rx_data = 8'h7E;
        drive(1, 32'h30000, 0, 8'h00);
        chk("rx_pop in request cycle", {31'h0, rx_pop}, 32'h1);
        chk("rx read data", {24'h0, mem_rdata}, 32'h7E);
        idle();
        chk("rx_pop single pulse", {31'h0, rx_pop}, 32'h0);
        rx_valid = 0;
        drive(1, 32'h30000, 0, 8'h00);
        chk("rx empty pop", {31'h0, rx_pop}, 32'h0);
        chk("rx empty read", {24'h0, mem_rdata}, 32'h0);

        // unmapped I/O
        drive(1, 32'h10, 0, 8'h00);
        drive(1, 32'h30008, 0, 8'h00);
        chk("unmapped io read", {24'h0, mem_rdata}, 32'h0);
        drive(1, 32'h30008, 1, 8'h55);
        chk("unmapped io write", {31'h0, tx_valid}, 32'h0);

        // counter across wrap
        preset_val = 32'hFFFF_FFFE;
        force dut.cycle_cnt = 32'hFFFF_FFFE;
        preset_seq++;
        #1;
        release dut.cycle_cnt;
        drive(1, 32'h30004, 0, 8'h00);
        chk("counter byte0", {24'h0, mem_rdata}, 32'hFE);
        drive(1, 32'h30005, 0, 8'h00);
        chk("counter byte1", {24'h0, mem_rdata}, 32'hFF);
        drive(1, 32'h30006, 0, 8'h00);
`ifdef MEM_IO_CYCLE_SNAPSHOT_EN
        chk("counter byte2", {24'h0, mem_rdata}, 32'hFF);
`else
        chk("counter byte2", {24'h0, mem_rdata}, 32'h00);
`endif
        drive(1, 32'h30007, 0, 8'h00);
`ifdef MEM_IO_CYCLE_SNAPSHOT_EN
        chk("counter byte3", {24'h0, mem_rdata}, 32'hFF);
`else
        chk("counter byte3", {24'h0, mem_rdata}, 32'h00);
`endif

        // reset mid-drain
        tx_ready = 0;
        drive(1, 32'h30000, 1, 8'h11);
        drive(1, 32'h30000, 1, 8'h22);
        drive(1, 32'h30000, 1, 8'h33);
        tx_ready = 1;
        idle();
        chk("mid-drain head", {24'h0, tx_data}, 32'h22);
        rst_in = 1'b0;
        #1;
        chk("reset tx_valid immediate", {31'h0, tx_valid}, 32'h0);
        chk("reset clears stop", {31'h0, program_stop}, 32'h0);
        chk("reset clears rdata", {24'h0, mem_rdata}, 32'h0);
        tx_ready = 0;
        repeat (2) cyc();
        rst_in = 1'b1;
        drive(1, 32'h10, 0, 8'h00);
        chk("ram survives reset", {24'h0, mem_rdata}, 32'hA5);
        drive(1, 32'h30004, 0, 8'h00);
        chk("counter after reset", {24'h0, mem_rdata}, 32'h01);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
